round_key_sequencer: RTL and testbench
======================================

Name: round_key_sequencer

Overview:
- Sits directly downstream of the AES key scheduler.
- Captures the full expanded round-key vector, either on a new key or held pending while a block is in flight.
- Serves one 128-bit round key per accepted handshake to an iterative AES round engine, from round 0 to round N_ROUNDS.
- Lets one key expansion feed many data blocks without re-expanding the key.

Parameters:
- NB_BYTE, 8: bits per byte; only 8 is supported.
- N_BYTES_STATE, 16: bytes per round key (AES state).
- N_ROUNDS, 14: number of cipher rounds; 10, 12 or 14. The block serves N_ROUNDS+1 keys.

Derived values:
- NB_RK = N_BYTES_STATE*NB_BYTE (128).
- NB_IDX = clog2(N_ROUNDS+1) (4).

Ports:
- i_clock, in, 1: single clock, rising edge.
- i_reset_n, in, 1: asynchronous active-low reset.
- i_round_key_vector, in, NB_RK*(N_ROUNDS+1): expanded keys; round r sits at slice [r*NB_RK +: NB_RK], round 0 in the LSB slice.
- i_key_valid, in, 1: single-cycle pulse; i_round_key_vector is valid this cycle.
- i_start, in, 1: request to sequence one block; level, held until accepted.
- o_start_ready, out, 1: high when i_start will be accepted.
- i_abort, in, 1: synchronous abort of the current block.
- o_round_key, out, NB_RK: current round key.
- o_round_idx, out, NB_IDX: round index of o_round_key.
- o_round_key_valid, out, 1: o_round_key/o_round_idx are valid.
- i_round_key_ready, in, 1: downstream accepts the key this cycle.
- o_first, out, 1: o_round_idx==0 while valid.
- o_last, out, 1: o_round_idx==N_ROUNDS while valid.
- o_key_loaded, out, 1: an active key bank is present.
- o_key_pending, out, 1: a new key is waiting to replace the active bank.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - State IDLE.
  - Active bank, pending bank, pending flag, index and all outputs go to 0.
- States:
  - IDLE: no key loaded.
  - READY: key loaded, no block in flight.
  - RUN: sequencing a block.
- IDLE:
  - i_key_valid copies the vector into the active bank; next state READY.
  - o_start_ready=0; i_start is ignored.
- READY:
  - o_start_ready=1.
  - i_key_valid overwrites the active bank.
  - i_start goes to RUN with index 0.
  - i_key_valid and i_start in the same cycle: the new key is written and the block uses the new key.
- RUN:
  - o_round_key_valid=1. Outputs are registered and come from the active bank at the current index.
  - Outputs hold stable while valid && !i_round_key_ready.
  - Each accepted handshake (valid && ready) increments the index at the edge.
  - Accept at index N_ROUNDS: valid drops next cycle; next state READY.
  - If pending is set at that point, the pending bank is copied to active and pending clears on the same edge.
- Key arriving during RUN:
  - i_key_valid stores the vector to the pending bank and sets pending.
  - A second pulse overwrites the pending bank.
  - The active bank never changes mid-block.
- Abort:
  - i_abort in RUN forces READY next edge and valid drops next cycle.
  - Pending is applied exactly as on normal completion.
  - i_abort has priority over a same-cycle handshake.
  - i_abort outside RUN has no effect.
- Latency: i_start accepted at edge k gives round 0 valid in cycle k+1. With ready held high, round N_ROUNDS is presented in cycle k+1+N_ROUNDS.
- Back-to-back blocks: o_start_ready is 0 throughout RUN. The earliest next start is accepted in the first READY cycle, which leaves a one-cycle bubble.
- Status outputs:
  - o_key_loaded=1 in READY and RUN.
  - o_key_pending mirrors the pending flag.
  - o_first and o_last are 0 whenever valid=0.
- Reset asserted mid-block: everything clears immediately, including the key banks. A fresh i_key_valid is required afterwards.

Test Plan:
- Reset then load: release reset, pulse i_key_valid with slice r = {16{r[7:0]}}, then hold i_start and ready=1 → valid in cycle after accept; idx 0..14, key = {16{idx}}; o_first on idx 0, o_last on idx 14; o_start_ready back to 1 after 15 keys.
- Backpressure: toggle i_round_key_ready pseudo-randomly during RUN → no key skipped or duplicated; outputs stable while ready=0; 15 handshakes total.
- Key during run: at idx 5 pulse i_key_valid with pattern B → remaining rounds still show pattern A; o_key_pending=1; after the last accept the next block emits B and pending=0.
- Simultaneous: in READY assert i_key_valid(B) and i_start together → round 0 = B slice 0.
- Abort: i_abort at idx 7 with ready=1 → valid low next cycle, state READY, o_start_ready=1; the next block restarts at idx 0.
- Async reset mid-run: drop i_reset_n at idx 3 without a clock edge → all outputs 0 immediately; i_start after release is ignored until i_key_valid.

Source files
------------

// File: rtl/round_key_sequencer.sv
// Holds an expanded AES key schedule and serves one round key per valid/ready handshake, round 0..N_ROUNDS.
// Round 0 is valid the cycle after start is accepted; outputs hold while ready is low; a key arriving mid-block waits in a pending bank.
module round_key_sequencer #(
  parameter int NB_BYTE       = 8,
  parameter int N_BYTES_STATE = 16,
  parameter int N_ROUNDS      = 14,
  localparam int NB_RK        = N_BYTES_STATE * NB_BYTE,
  localparam int NB_IDX       = $clog2(N_ROUNDS + 1)
) (
  input  logic                          i_clock,
  input  logic                          i_reset_n,
  input  logic [NB_RK*(N_ROUNDS+1)-1:0] i_round_key_vector,
  input  logic                          i_key_valid,
  input  logic                          i_start,
  output logic                          o_start_ready,
  input  logic                          i_abort,
  output logic [NB_RK-1:0]              o_round_key,
  output logic [NB_IDX-1:0]             o_round_idx,
  output logic                          o_round_key_valid,
  input  logic                          i_round_key_ready,
  output logic                          o_first,
  output logic                          o_last,
  output logic                          o_key_loaded,
  output logic                          o_key_pending
);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN} state_t;

  localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_ROUNDS);

  typedef logic [N_ROUNDS:0][NB_RK-1:0] bank_t;

  state_t              state, state_nxt;
  bank_t               active_bank, active_nxt;
  bank_t               pend_bank, pend_bank_nxt;
  logic                pend, pend_nxt;
  logic [NB_IDX-1:0]   idx, idx_nxt;
  logic [NB_RK-1:0]    key_nxt;
  logic                valid_nxt, first_nxt, last_nxt;
  logic                handshake;

  assign handshake = o_round_key_valid && i_round_key_ready;

  always_comb begin
    state_nxt     = state;
    active_nxt    = active_bank;
    pend_bank_nxt = pend_bank;
    pend_nxt      = pend;
    idx_nxt       = idx;
    case (state)
      S_IDLE: begin
        if (i_key_valid) begin
          active_nxt = i_round_key_vector;
          state_nxt  = S_READY;
        end
      end
      S_READY: begin
        if (i_key_valid) active_nxt = i_round_key_vector;
        if (i_start) begin
          state_nxt = S_RUN;
          idx_nxt   = '0;
        end
      end
      S_RUN: begin
        if (i_key_valid) begin
          pend_bank_nxt = i_round_key_vector;
          pend_nxt      = 1'b1;
        end
        // Abort wins over a same-cycle handshake; a key arriving on the final edge is promoted too.
        if (i_abort || (handshake && idx == LAST_IDX)) begin
          state_nxt = S_READY;
          idx_nxt   = '0;
          if (pend_nxt) begin
            active_nxt = pend_bank_nxt;
            pend_nxt   = 1'b0;
          end
        end else if (handshake) begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    valid_nxt = (state_nxt == S_RUN);
    key_nxt   = valid_nxt ? active_nxt[idx_nxt] : '0;
    first_nxt = valid_nxt && (idx_nxt == '0);
    last_nxt  = valid_nxt && (idx_nxt == LAST_IDX);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state             <= S_IDLE;
      active_bank       <= '0;
      pend_bank         <= '0;
      pend              <= 1'b0;
      idx               <= '0;
      o_round_key       <= '0;
      o_round_key_valid <= 1'b0;
      o_first           <= 1'b0;
      o_last            <= 1'b0;
    end else begin
      state             <= state_nxt;
      active_bank       <= active_nxt;
      pend_bank         <= pend_bank_nxt;
      pend              <= pend_nxt;
      idx               <= idx_nxt;
      o_round_key       <= key_nxt;
      o_round_key_valid <= valid_nxt;
      o_first           <= first_nxt;
      o_last            <= last_nxt;
    end
  end

  assign o_round_idx   = idx;
  assign o_start_ready = (state == S_READY);
  assign o_key_loaded  = (state != S_IDLE);
  assign o_key_pending = pend;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed bench for round_key_sequencer: load, sequencing, backpressure, pending key, abort, async reset.
module tb_round_key_sequencer;

  localparam int NR    = 14;
  localparam int NB_RK = 128;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NB_RK*(NR+1)-1:0]  vec;
  logic                     key_valid, start, abort, rk_ready;
  logic                     start_ready, rk_valid, first, last, loaded, pending;
  logic [NB_RK-1:0]         rk;
  logic [3:0]               ridx;

  logic [NB_RK*(NR+1)-1:0]  vec_a, vec_b;
  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  round_key_sequencer #(.NB_BYTE(8), .N_BYTES_STATE(16), .N_ROUNDS(NR)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_round_key_vector(vec), .i_key_valid(key_valid),
    .i_start(start), .o_start_ready(start_ready), .i_abort(abort), .o_round_key(rk),
    .o_round_idx(ridx), .o_round_key_valid(rk_valid), .i_round_key_ready(rk_ready),
    .o_first(first), .o_last(last), .o_key_loaded(loaded), .o_key_pending(pending)
  );

  function automatic logic [NB_RK-1:0] ka(input int r);
    logic [7:0] b;
    b = r[7:0];
    return {16{b}};
  endfunction

  function automatic logic [NB_RK-1:0] kb(input int r);
    logic [7:0] b;
    b = 8'h80 | r[7:0];
    return {16{b}};
  endfunction

  task automatic chk(input string tag, input logic [NB_RK-1:0] obs, input logic [NB_RK-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the presented key for round r of the given pattern.
  task automatic chk_round(input string tag, input int r, input bit pat_b);
    chk({tag, " valid"}, 128'(rk_valid), 128'(1'b1));
    chk({tag, " idx"}, 128'(ridx), 128'(r));
    chk({tag, " key"}, rk, pat_b ? kb(r) : ka(r));
    chk({tag, " first"}, 128'(first), 128'(r == 0));
    chk({tag, " last"}, 128'(last), 128'(r == NR));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " valid"}, 128'(rk_valid), 128'(1'b0));
    chk({tag, " first"}, 128'(first), 128'(1'b0));
    chk({tag, " last"}, 128'(last), 128'(1'b0));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] bp;
    int e, c;
    bit hs;

    for (int r = 0; r <= NR; r++) begin
      vec_a[r*NB_RK +: NB_RK] = ka(r);
      vec_b[r*NB_RK +: NB_RK] = kb(r);
    end
    bp = 16'b1011_0010_1101_0110;
    rst_n = 1'b0; vec = '0; key_valid = 0; start = 0; abort = 0; rk_ready = 0;
    #12;
    // Reset state
    chk("rst key", rk, '0);
    chk("rst idx", 128'(ridx), '0);
    chk_idle_outputs("rst");
    chk("rst start_ready", 128'(start_ready), '0);
    chk("rst loaded", 128'(loaded), '0);
    chk("rst pending", 128'(pending), '0);
    rst_n = 1'b1;
    tick();

    // Start is ignored in IDLE
    start = 1; tick(); start = 0;
    chk_idle_outputs("idle start");
    chk("idle start_ready", 128'(start_ready), '0);

    // Load A
    vec = vec_a; key_valid = 1; tick(); key_valid = 0;
    chk("load loaded", 128'(loaded), 128'(1'b1));
    chk("load start_ready", 128'(start_ready), 128'(1'b1));
    chk_idle_outputs("load");

    // Full block, ready held high
    rk_ready = 1; start = 1; tick(); start = 0;
    chk_round("blk1 r0", 0, 0);
    chk("blk1 start_ready busy", 128'(start_ready), '0);
    for (int r = 1; r <= NR; r++) begin
      tick();
      chk_round("blk1", r, 0);
    end
    tick();
    chk_idle_outputs("blk1 end");
    chk("blk1 end start_ready", 128'(start_ready), 128'(1'b1));

    // Backpressure
    start = 1; tick(); start = 0;
    chk_round("bp r0", 0, 0);
    e = 0;
    for (c = 0; c < 80; c++) begin
      rk_ready = bp[c % 16];
      hs = rk_ready;
      tick();
      if (hs) e++;
      if (e == NR + 1) break;
      chk_round("bp", e, 0);
    end
    chk("bp handshakes", 128'(e), 128'(NR + 1));
    chk_idle_outputs("bp end");

    // Key B arriving during run at idx 5
    rk_ready = 1; start = 1; tick(); start = 0;
    chk_round("kr r0", 0, 0);
    for (int r = 1; r <= 5; r++) tick();
    chk_round("kr r5", 5, 0);
    vec = vec_b; key_valid = 1; tick(); key_valid = 0;
    chk_round("kr r6", 6, 0);
    chk("kr pending set", 128'(pending), 128'(1'b1));
    for (int r = 7; r <= NR; r++) begin
      tick();
      chk_round("kr", r, 0);
    end
    tick();
    chk_idle_outputs("kr end");
    chk("kr pending clear", 128'(pending), '0);
    start = 1; tick(); start = 0;
    for (int r = 0; r <= NR; r++) begin
      if (r != 0) tick();
      chk_round("blkB", r, 1);
    end
    tick();

    // Simultaneous load of A and start: block uses A
    vec = vec_a; key_valid = 1; start = 1; tick(); key_valid = 0; start = 0;
    chk_round("sim r0", 0, 0);
    for (int r = 1; r <= 7; r++) tick();
    chk_round("ab r7", 7, 0);

    // Abort at idx 7 beats the same-cycle handshake
    abort = 1; tick(); abort = 0;
    chk_idle_outputs("ab");
    chk("ab start_ready", 128'(start_ready), 128'(1'b1));
    chk("ab idx", 128'(ridx), '0);
    chk("ab loaded", 128'(loaded), 128'(1'b1));
    start = 1; tick(); start = 0;
    chk_round("ab restart", 0, 0);

    // Async reset mid-run
    for (int r = 1; r <= 3; r++) tick();
    chk_round("ar r3", 3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("ar");
    chk("ar key", rk, '0);
    chk("ar idx", 128'(ridx), '0);
    chk("ar loaded", 128'(loaded), '0);
    chk("ar start_ready", 128'(start_ready), '0);
    #3 rst_n = 1'b1;
    start = 1; tick(); tick(); start = 0;
    chk_idle_outputs("ar start ignored");
    chk("ar start_ready idle", 128'(start_ready), '0);
    key_valid = 1; tick(); key_valid = 0;
    start = 1; tick(); start = 0;
    chk_round("ar reload", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
